// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FSM state, default widths and arithmetic helpers for fir_mac_reader
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POP  = 3'd1,
    LOAD = 3'd2,
    MAC  = 3'd3,
    OUT  = 3'd4
  } fir_state_e;

  localparam int DWIDTH_DEF = 8;
  localparam int CWIDTH_DEF = 8;
  localparam int TAPS_DEF   = 16;

  // Full-precision accumulator width: product width plus growth for TAPS additions.
  function automatic int calc_owidth(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/fir_mac_reader_coef_bank.sv
// rtl/fir_mac_reader_coef_bank.sv - TAPS x CWIDTH coefficient register file
// Synchronous write port, asynchronous read at the current tap index.
module fir_coef_bank #(
  parameter int CWIDTH = 8,
  parameter int TAPS   = 16,
  parameter int TWIDTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_we,
  input  logic [TWIDTH-1:0]        i_waddr,
  input  logic signed [CWIDTH-1:0] i_wdata,
  input  logic [TWIDTH-1:0]        i_raddr,
  output logic signed [CWIDTH-1:0] o_rdata
);

  logic signed [CWIDTH-1:0] r_coef [TAPS];
  logic                     w_addr_ok;

  // Only a non-power-of-two TAPS leaves addresses that must be rejected.
  if ((1 << TWIDTH) > TAPS) begin : g_addr_chk
    assign w_addr_ok = (int'(i_waddr) < TAPS);
  end else begin : g_addr_full
    assign w_addr_ok = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_coef[i] <= '0;
      end
    end else if (i_we && w_addr_ok) begin
      r_coef[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_coef[i_raddr];

endmodule

// File: rtl/fir_mac_reader.sv
// rtl/fir_mac_reader.sv - FIFO-fed serial-MAC FIR filter with valid/ready result register
// Optional FIR_MAC_OUT_SAT_EN: round, shift by SHIFT and saturate to DWIDTH (one extra cycle).
module fir_mac_reader
  import fir_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int CWIDTH = CWIDTH_DEF,
  parameter int TAPS   = TAPS_DEF,
  parameter int TWIDTH = $clog2(TAPS),
  parameter int OWIDTH = calc_owidth(DWIDTH, CWIDTH, TAPS),
  parameter int SHIFT  = 7
) (
  input  logic                     rd_clk,
  input  logic                     areset_n,
  input  logic                     fifo_empty,
  input  logic signed [DWIDTH-1:0] fifo_q,
  output logic                     fifo_rd,
  input  logic                     coef_we,
  input  logic [TWIDTH-1:0]        coef_addr,
  input  logic signed [CWIDTH-1:0] coef_data,
  input  logic                     flush,
  output logic                     busy,
  output logic signed [OWIDTH-1:0] dout,
  output logic                     dout_valid,
  input  logic                     dout_ready
);

  if (TAPS < 2 || SHIFT < 1 || TWIDTH != $clog2(TAPS) || OWIDTH < DWIDTH + CWIDTH + TWIDTH) begin : g_bad_params
    $error("fir_mac_reader: inconsistent parameters");
  end

  fir_state_e               r_state;
  fir_state_e               w_state_next;
  logic                     r_fifo_rd;
  logic                     r_dout_valid;
  logic signed [OWIDTH-1:0] r_dout;
  logic signed [OWIDTH-1:0] r_acc;
  logic signed [DWIDTH-1:0] r_x [TAPS];
  logic [TWIDTH-1:0]        r_k;

  logic                            w_busy;
  logic                            w_pop_next;
  logic                            w_last;
  logic                            w_coef_we;
  logic signed [CWIDTH-1:0]        w_coef;
  logic signed [DWIDTH+CWIDTH-1:0] w_prod;
  logic signed [OWIDTH-1:0]        w_prod_ext;
  logic signed [OWIDTH-1:0]        w_acc_next;

  // Writes are only safe while the MAC is not reading the bank and no result is pending.
  assign w_coef_we = coef_we && !w_busy && !r_dout_valid;

  fir_coef_bank #(
    .CWIDTH (CWIDTH),
    .TAPS   (TAPS),
    .TWIDTH (TWIDTH)
  ) u_coef_bank (
    .i_clk   (rd_clk),
    .i_rst_n (areset_n),
    .i_we    (w_coef_we),
    .i_waddr (coef_addr),
    .i_wdata (coef_data),
    .i_raddr (r_k),
    .o_rdata (w_coef)
  );

  assign w_last     = (r_k == TWIDTH'(TAPS - 1));
  assign w_prod     = r_x[r_k] * w_coef;
  assign w_prod_ext = {{(OWIDTH - DWIDTH - CWIDTH){w_prod[DWIDTH+CWIDTH-1]}}, w_prod};
  assign w_acc_next = r_acc + w_prod_ext;

  always_ff @(posedge rd_clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A flush in IDLE wins over a pop; the pop is taken one cycle later.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (!flush && !fifo_empty && !r_dout_valid) w_state_next = POP;
      POP:  w_state_next = LOAD;
      LOAD: w_state_next = MAC;
      MAC:  if (w_last) w_state_next = OUT;
      OUT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy     = (r_state != IDLE);
    w_pop_next = (w_state_next == POP);
  end

  always_ff @(posedge rd_clk or negedge areset_n) begin
    if (!areset_n) begin
      r_fifo_rd <= 1'b0;
    end else begin
      r_fifo_rd <= w_pop_next;
    end
  end

  always_ff @(posedge rd_clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_x[i] <= '0;
      end
      r_acc <= '0;
      r_k   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (flush) begin
            for (int i = 0; i < TAPS; i++) begin
              r_x[i] <= '0;
            end
          end
        end
        LOAD: begin
          r_x[0] <= fifo_q;
          for (int i = 1; i < TAPS; i++) begin
            r_x[i] <= r_x[i-1];
          end
          r_acc <= '0;
          r_k   <= '0;
        end
        MAC: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rd_clk or negedge areset_n) begin
    if (!areset_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end
`ifdef FIR_MAC_OUT_SAT_EN
      if (r_state == OUT) begin
        r_dout       <= OWIDTH'(sat_signed((64'(r_acc) + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT, DWIDTH));
        r_dout_valid <= 1'b1;
      end
`else
      if (r_state == MAC && w_last) begin
        r_dout       <= w_acc_next;
        r_dout_valid <= 1'b1;
      end
`endif
    end
  end

  assign fifo_rd    = r_fifo_rd;
  assign busy       = w_busy;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_fir_mac_reader.sv
// tb/tb_fir_mac_reader.sv - directed self-checking bench for fir_mac_reader (TAPS=4)
module tb_fir_mac_reader;

  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int TAPS = 4;
  localparam int TW   = 2;
  localparam int OW   = 18;

  logic          rd_clk = 1'b0;
  logic          areset_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_q = '0;
  logic          fifo_rd;
  logic          coef_we;
  logic [TW-1:0] coef_addr;
  logic [CW-1:0] coef_data;
  logic          flush;
  logic          busy;
  logic [OW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [64];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  int   rd_total = 0;
  int   viol = 0;
  logic gate = 1'b0;
  logic toggle_en = 1'b0;
  logic emp_d = 1'b1;
  int   res [64];
  int   res_cnt = 0;
  int   lat [64];
  int   lat_cnt = 0;
  int   cyc = 0;
  int   rd_cyc = 0;
  logic pv = 1'b0;

  always #5 rd_clk = ~rd_clk;

  fir_mac_reader #(
    .DWIDTH (DW),
    .CWIDTH (CW),
    .TAPS   (TAPS),
    .TWIDTH (TW),
    .OWIDTH (OW),
    .SHIFT  (7)
  ) dut (
    .rd_clk     (rd_clk),
    .areset_n   (areset_n),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rd    (fifo_rd),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .flush      (flush),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  assign fifo_empty = (wr_ptr == rd_ptr) || gate;

  // FIFO model and result/pop monitor
  always @(posedge rd_clk) begin
    if (fifo_rd) begin
      if (wr_ptr == rd_ptr || emp_d) viol++;
      fifo_q   <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + 1;
      rd_total++;
    end
    emp_d = fifo_empty;
    gate <= toggle_en ? ~gate : 1'b0;
    if (dout_valid && dout_ready) begin
      res[res_cnt] = $signed(dout);
      res_cnt++;
    end
    cyc++;
  end

  always @(negedge rd_clk) begin
    if (fifo_rd) rd_cyc = cyc;
    if (dout_valid && !pv) begin
      lat[lat_cnt] = cyc - rd_cyc;
      lat_cnt++;
    end
    pv = dout_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  task automatic wc(input int addr, input int data);
    @(posedge rd_clk); #1;
    coef_we   = 1'b1;
    coef_addr = TW'(addr);
    coef_data = CW'(data);
    @(posedge rd_clk); #1;
    coef_we   = 1'b0;
  endtask

  task automatic do_flush();
    @(posedge rd_clk); #1;
    flush = 1'b1;
    @(posedge rd_clk); #1;
    flush = 1'b0;
  endtask

  task automatic push(input int v);
    mem[wr_ptr] = DW'(v);
    wr_ptr++;
  endtask

  task automatic wait_results(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (res_cnt < target && n < budget) begin
      @(posedge rd_clk);
      n++;
    end
    #1;
    checks++;
    if (res_cnt < target) begin
      errors++;
      $display("FAIL %s timeout: results %0d, required %0d", name, res_cnt, target);
    end
    tick(2);
  endtask

  task automatic test_reset();
    areset_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    flush = 1'b0; dout_ready = 1'b0;
    tick(3);
    areset_n = 1'b1;
    @(negedge rd_clk);
    checks++; if (fifo_rd !== 1'b0)    begin errors++; $display("FAIL reset_fifo_rd got %b exp 0", fifo_rd); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
    checks++; if (dout !== '0)         begin errors++; $display("FAIL reset_dout got %0d exp 0", dout); end
  endtask

  task automatic test_impulse();
    int rb, lb;
    int exp_v [4] = '{1, 2, 3, 4};
    wc(0, 1); wc(1, 2); wc(2, 3); wc(3, 4);
    rb = res_cnt; lb = lat_cnt;
    dout_ready = 1'b1;
    push(1); push(0); push(0); push(0);
    wait_results(rb + 4, 200, "impulse");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res[rb+i] !== exp_v[i]) begin errors++; $display("FAIL impulse_dout[%0d] got %0d exp %0d", i, res[rb+i], exp_v[i]); end
      checks++;
      if (lat[lb+i] !== TAPS + 2) begin errors++; $display("FAIL impulse_latency[%0d] got %0d exp %0d", i, lat[lb+i], TAPS + 2); end
    end
  endtask

  task automatic test_full_scale();
    int rb;
    do_flush();
    for (int i = 0; i < 4; i++) wc(i, 127);
    rb = res_cnt;
    for (int i = 0; i < 4; i++) push(-128);
    wait_results(rb + 4, 200, "full_scale");
    checks++; if (res[rb] !== -16256)   begin errors++; $display("FAIL full_scale_first got %0d exp -16256", res[rb]); end
    checks++; if (res[rb+3] !== -65024) begin errors++; $display("FAIL full_scale_last got %0d exp -65024", res[rb+3]); end
  endtask

  task automatic test_backpressure();
    int rb, n, bad;
    logic [OW-1:0] held;
    do_flush();
    wc(0, 1); wc(1, 0); wc(2, 0); wc(3, 0);
    rb = res_cnt;
    dout_ready = 1'b0;
    push(7); push(8); push(9);
    n = 0;
    @(negedge rd_clk);
    while (!dout_valid && n < 100) begin @(negedge rd_clk); n++; end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got %b exp 1", dout_valid); end
    held = dout;
    checks++; if (held !== OW'(7)) begin errors++; $display("FAIL bp_first_dout got %0d exp 7", held); end
    bad = 0;
    repeat (20) begin
      @(negedge rd_clk);
      if (dout !== held || fifo_rd !== 1'b0 || dout_valid !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
    @(posedge rd_clk); #1;
    dout_ready = 1'b1;
    @(negedge rd_clk);
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL bp_handshake_valid got %b exp 1", dout_valid); end
    @(negedge rd_clk);
    checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL bp_rd_h1 got %b exp 0", fifo_rd); end
    @(negedge rd_clk);
    checks++; if (fifo_rd !== 1'b1) begin errors++; $display("FAIL bp_rd_resume got %b exp 1", fifo_rd); end
    wait_results(rb + 3, 200, "bp_drain");
    checks++; if (res[rb+1] !== 8) begin errors++; $display("FAIL bp_second got %0d exp 8", res[rb+1]); end
    checks++; if (res[rb+2] !== 9) begin errors++; $display("FAIL bp_third got %0d exp 9", res[rb+2]); end
  endtask

  task automatic test_empty_toggle();
    int rb, rd0, v0;
    rb = res_cnt; rd0 = rd_total; v0 = viol;
    dout_ready = 1'b1;
    toggle_en = 1'b1;
    push(11); push(22); push(33);
    wait_results(rb + 3, 300, "toggle");
    toggle_en = 1'b0;
    tick(2);
    checks++; if (viol !== v0) begin errors++; $display("FAIL toggle_rd_while_empty got %0d exp %0d", viol, v0); end
    checks++; if (rd_total - rd0 !== 3) begin errors++; $display("FAIL toggle_pop_count got %0d exp 3", rd_total - rd0); end
    checks++; if (res_cnt - rb !== 3) begin errors++; $display("FAIL toggle_out_count got %0d exp 3", res_cnt - rb); end
    checks++; if (res[rb+2] !== 33) begin errors++; $display("FAIL toggle_value got %0d exp 33", res[rb+2]); end
  endtask

  task automatic test_reset_mid_mac();
    int rb, n;
    wc(0, 1);
    rb = res_cnt;
    dout_ready = 1'b1;
    push(50);
    n = 0;
    @(negedge rd_clk);
    while (!fifo_rd && n < 50) begin @(negedge rd_clk); n++; end
    checks++; if (fifo_rd !== 1'b1) begin errors++; $display("FAIL rst_mid_pop_timeout got %b exp 1", fifo_rd); end
    repeat (3) @(negedge rd_clk);
    areset_n = 1'b0;
    @(negedge rd_clk);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", dout_valid); end
    @(posedge rd_clk); #1;
    areset_n = 1'b1;
    tick(10);
    checks++; if (res_cnt !== rb) begin errors++; $display("FAIL rst_mid_abandoned got %0d outputs exp %0d", res_cnt, rb); end
    wc(0, 2);
    push(5);
    wait_results(rb + 1, 100, "rst_mid");
    checks++; if (res[rb] !== 10) begin errors++; $display("FAIL rst_mid_dout got %0d exp 10", res[rb]); end
  endtask

  task automatic test_flush();
    int rb;
    for (int i = 0; i < 4; i++) wc(i, 1);
    rb = res_cnt;
    push(3);
    wait_results(rb + 1, 100, "flush_pre");
    checks++; if (res[rb] !== 8) begin errors++; $display("FAIL flush_pre got %0d exp 8", res[rb]); end
    do_flush();
    push(0);
    wait_results(rb + 2, 100, "flush_post");
    checks++; if (res[rb+1] !== 0) begin errors++; $display("FAIL flush_post got %0d exp 0", res[rb+1]); end
  endtask

  task automatic test_coef_drop();
    int rb, n;
    rb = res_cnt;
    dout_ready = 1'b0;
    push(4);
    n = 0;
    @(negedge rd_clk);
    while (!busy && n < 50) begin @(negedge rd_clk); n++; end
    @(posedge rd_clk); #1;
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd100;
    tick(2);
    coef_we = 1'b0;
    n = 0;
    while (!dout_valid && n < 50) begin @(posedge rd_clk); #1; n++; end
    coef_we = 1'b1; coef_addr = 2'd1; coef_data = 8'd50;
    tick(1);
    coef_we = 1'b0;
    dout_ready = 1'b1;
    wait_results(rb + 1, 100, "drop_first");
    checks++; if (res[rb] !== 4) begin errors++; $display("FAIL drop_busy got %0d exp 4", res[rb]); end
    push(6);
    wait_results(rb + 2, 100, "drop_second");
    checks++; if (res[rb+1] !== 10) begin errors++; $display("FAIL drop_valid got %0d exp 10", res[rb+1]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_full_scale();
    test_backpressure();
    test_empty_toggle();
    test_reset_mid_mac();
    test_flush();
    test_coef_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
